// File: rtl/fir_ser_pkg.sv
// Shared state encoding, sizing helper and parity helper for the FIR result serializer.
package fir_ser_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETUP      = 2'd1,
    WAIT_ACK_H = 2'd2,
    WAIT_ACK_L = 2'd3
  } ser_state_t;

  localparam int ACK_SYNC_STAGES = 2;

  function automatic int fir_nbytes(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic logic even_parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fir_ser_fifo.sv
// Word buffer between the filter datapath and the byte serializer.
// Push when full and pop when empty are ignored; DEPTH must be a power of two.
module fir_ser_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage array is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_result_serializer.sv
// Buffers filter words and sends them MSB byte first over a 4-phase req/ack link.
// Optional build macro SER_PARITY_EN adds a registered even-parity bit on out_parity.
module fir_result_serializer
  import fir_ser_pkg::*;
#(
  parameter int DATA_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_req,
  output logic              out_first,
  output logic              out_parity,
  input  logic              host_ack,
  output logic              overflow
);

  localparam int NBYTES = fir_nbytes(DATA_W);
  localparam int SER_W  = NBYTES * 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  ser_state_t                 r_state;
  logic [ACK_SYNC_STAGES-1:0] r_ack_sync;
  logic [SER_W-1:0]           r_shift;
  logic [IDX_W-1:0]           r_idx;
  logic [7:0]                 r_out_byte;
  logic                       r_out_req;
  logic                       r_out_first;
  logic                       r_overflow;

  logic              w_ack_s;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_fifo_data;
  logic [SER_W-1:0]  w_word_ext;
  logic [SER_W-1:0]  w_load_src;
  logic [7:0]        w_load_byte;
  logic              w_push;
  logic              w_pop;
  logic              w_more;
  logic              w_next;
  logic              w_load;

  assign in_ready = ena && !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_ack_s  = r_ack_sync[ACK_SYNC_STAGES-1];
  assign w_pop    = ena && (r_state == IDLE) && !w_empty && !w_ack_s;
  assign w_more   = (r_idx != IDX_W'(NBYTES - 1));
  assign w_next   = ena && (r_state == WAIT_ACK_L) && !w_ack_s && w_more;
  assign w_load   = w_pop || w_next;

  fir_ser_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_data),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  generate
    if (SER_W > DATA_W) begin : g_sext
      assign w_word_ext = {{(SER_W - DATA_W){w_fifo_data[DATA_W-1]}}, w_fifo_data};
    end else begin : g_nosext
      assign w_word_ext = w_fifo_data;
    end
  endgenerate

  // A fresh word is loaded from the FIFO; later bytes come from the pre-shifted register.
  always_comb begin
    w_load_src  = r_shift;
    w_load_byte = 8'h00;
    if (r_state == IDLE) begin
      w_load_src = w_word_ext;
    end else begin
      w_load_src = r_shift;
    end
    w_load_byte = w_load_src[SER_W-1 -: 8];
  end

  // Ack synchronizer keeps sampling even while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= {ACK_SYNC_STAGES{1'b0}};
    end else begin
      r_ack_sync <= {r_ack_sync[ACK_SYNC_STAGES-2:0], host_ack};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (ena && in_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= {SER_W{1'b0}};
      r_idx       <= {IDX_W{1'b0}};
      r_out_byte  <= 8'h00;
      r_out_req   <= 1'b0;
      r_out_first <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_idx       <= {IDX_W{1'b0}};
            r_out_first <= 1'b1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_out_req <= 1'b1;
          r_state   <= WAIT_ACK_H;
        end
        WAIT_ACK_H: begin
          if (w_ack_s) begin
            r_out_req <= 1'b0;
            r_state   <= WAIT_ACK_L;
          end
        end
        WAIT_ACK_L: begin
          if (!w_ack_s) begin
            if (w_more) begin
              r_idx       <= r_idx + 1'b1;
              r_out_first <= 1'b0;
              r_state     <= SETUP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_out_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
      if (w_load) begin
        r_out_byte <= w_load_byte;
        r_shift    <= {w_load_src[SER_W-9:0], 8'h00};
      end
    end
  end

`ifdef SER_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= even_parity8(w_load_byte);
    end
  end

  assign out_parity = r_parity;
`else
  assign out_parity = 1'b0;
`endif

  assign out_byte  = r_out_byte;
  assign out_req   = r_out_req;
  assign out_first = r_out_first;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_result_serializer.sv
// Directed and randomized bench for fir_result_serializer with a byte-queue reference model.
module tb_fir_result_serializer;

  localparam int DATA_W     = 20;
  localparam int FIFO_DEPTH = 4;
  localparam int NB         = (DATA_W + 7) / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_byte;
  logic              out_req;
  logic              out_first;
  logic              out_parity;
  logic              host_ack;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_first_q[$];

  always #5 clk = ~clk;

  fir_result_serializer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_byte   (out_byte),
    .out_req    (out_req),
    .out_first  (out_first),
    .out_parity (out_parity),
    .host_ack   (host_ack),
    .overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [7:0] b);
`ifdef SER_PARITY_EN
    return ($countones(b) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // Two's-complement value reduced modulo 2^(8*NB), then split MSB byte first.
  task automatic model_word(input logic [DATA_W-1:0] w);
    longint v;
    longint ext;
    v = longint'(w);
    if (w[DATA_W-1]) v = v - (longint'(1) << DATA_W);
    ext = v & ((longint'(1) << (8 * NB)) - 1);
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(8'((ext >> (8 * (NB - 1 - k))) & 255));
      exp_first_q.push_back(k == 0);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input logic exp_acc);
    in_data  = w;
    in_valid = 1'b1;
    chk("in_ready", in_ready, exp_acc);
    if (exp_acc) model_word(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (out_req !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, n < 300, 1);
  endtask

  task automatic serve_byte(input int dly);
    int n;
    logic [7:0] eb;
    logic ef;
    eb = 8'h00;
    ef = 1'b0;
    wait_req("req_wait");
    chk("byte_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      ef = exp_first_q.pop_front();
    end
    chk("byte", out_byte, eb);
    chk("first", out_first, ef);
    chk("parity", out_parity, exp_par(eb));
    repeat (dly) begin
      tick();
      chk("hold_req", out_req, 1);
      chk("hold_byte", out_byte, eb);
    end
    host_ack = 1'b1;
    n = 0;
    while (out_req !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("req_drop", out_req, 0);
    chk("byte_held", out_byte, eb);
    host_ack = 1'b0;
    tick();
    chk("req_low_gap", out_req, 0);
  endtask

  task automatic no_extra(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (out_req !== 1'b0) seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    host_ack = 1'b0;
    repeat (3) tick();
    chk("rst_req", out_req, 0);
    chk("rst_byte", out_byte, 8'h00);
    chk("rst_first", out_first, 0);
    chk("rst_parity", out_parity, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Latency push -> req is 3 edges; byte is set up one cycle before req.
    push_word(20'h12345, 1'b1);
    chk("lat_a", out_req, 0);
    tick();
    chk("lat_b", out_req, 0);
    chk("setup_byte", out_byte, 8'h01);
    chk("setup_first", out_first, 1);
    tick();
    chk("lat_c", out_req, 1);
    repeat (NB) serve_byte(4);

    push_word(20'hFFFFD, 1'b1);
    repeat (NB) serve_byte(2);

    push_word(DATA_W'($urandom), 1'b1);
    repeat (NB) serve_byte(50);

    // Freeze with ena low mid-word while the host toggles ack.
    push_word(20'h12345, 1'b1);
    serve_byte(1);
    wait_req("freeze_req_wait");
    ena      = 1'b0;
    in_data  = 20'h55555;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_ack = (i % 2 == 0);
      tick();
      chk("frz_req", out_req, 1);
      chk("frz_byte", out_byte, 8'h23);
      chk("frz_first", out_first, 0);
      chk("frz_ready", in_ready, 0);
    end
    host_ack = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    chk("frz_parity", out_parity, exp_par(8'h23));
    repeat (NB - 1) serve_byte(3);
    chk("frz_no_ovf", overflow, 0);
    no_extra("no_extra_frz", 20);

    // Host holds ack high so nothing is popped: 4 words fit, the 5th overflows.
    host_ack = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) push_word(DATA_W'($urandom), i < 4);
    chk("ovf_set", overflow, 1);
    host_ack = 1'b0;
    repeat (4 * NB) serve_byte(int'($urandom_range(0, 3)));
    chk("ovf_sticky", overflow, 1);
    no_extra("no_extra_ovf", 20);

    // Reset in the middle of the last byte with another word queued.
    push_word(20'hABCDE, 1'b1);
    in_data  = 20'h13579;
    in_valid = 1'b1;
    chk("rst_q_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    serve_byte(1);
    serve_byte(1);
    wait_req("rst_req_wait");
    exp_q.delete();
    exp_first_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", out_req, 0);
    chk("rst_async_byte", out_byte, 8'h00);
    chk("rst_async_first", out_first, 0);
    chk("rst_async_ovf", overflow, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rel_ready", in_ready, 1);
    no_extra("no_stale", 30);

    // Randomized bursts: fill while the host holds ack, then drain.
    for (int r = 0; r < 6; r++) begin
      repeat (3) tick();
      host_ack = 1'b1;
      repeat (4) tick();
      k = $urandom_range(1, FIFO_DEPTH);
      for (int j = 0; j < int'(k); j++) begin
        push_word(DATA_W'($urandom), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      host_ack = 1'b0;
      repeat (int'(k) * NB) serve_byte(int'($urandom_range(0, 5)));
    end
    no_extra("no_extra_end", 20);
    chk("final_ovf", overflow, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
